// File: rtl/sync_handshake_arb.sv
// sync_handshake_arb
// Source-side controller for a 4-phase req/ack clock-domain-crossing link.
// NumReq local requesters share the link round-robin. One word is accepted per
// transaction and held stable on async_data_o/async_id_o while the remote side
// captures it. The remote acknowledge is synchronized through SyncStages flops.
//
// Optional feature: define SYNC_HANDSHAKE_ARB_TIMEOUT_EN to build the sticky
// stall detector behind timeout_o; otherwise timeout_o is tied low.
//
// Ports:
//   clk_i        source-domain clock
//   rst_i        asynchronous, active-high reset
//   req_valid_i  per-requester valid
//   req_ready_o  per-requester ready, one-hot or zero (accept strobe)
//   req_data_i   flattened payloads, requester k at [k*DataWidth +: DataWidth]
//   async_req_o  registered 4-phase request to the remote domain
//   async_data_o registered held payload
//   async_id_o   registered index of the payload owner
//   async_ack_i  remote acknowledge, asynchronous to clk_i
//   busy_o       high whenever the FSM is not IDLE
//   timeout_o    sticky stall flag
module sync_handshake_arb #(
  parameter int NumReq        = 4,
  parameter int DataWidth     = 32,
  parameter int SyncStages    = 2,
  parameter int TimeoutCycles = 1024,
  parameter int IdWidth       = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_valid_i,
  output logic [NumReq-1:0]           req_ready_o,
  input  logic [NumReq*DataWidth-1:0] req_data_i,
  output logic                        async_req_o,
  output logic [DataWidth-1:0]        async_data_o,
  output logic [IdWidth-1:0]          async_id_o,
  input  logic                        async_ack_i,
  output logic                        busy_o,
  output logic                        timeout_o
);

  // state  | meaning
  // IDLE   | link free; may accept when the synchronized ack is low
  // REQ_HI | async_req_o high, waiting for ack to rise
  // REQ_LO | async_req_o low, waiting for ack to fall
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [SyncStages-1:0] sync_q;
  logic                  ack_s;
  logic [IdWidth-1:0]    ptr_q;
  logic [IdWidth-1:0]    grant_idx;
  logic                  grant_vld;
  logic                  accept;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[SyncStages-2:0], async_ack_i};
  end

  assign ack_s = sync_q[SyncStages-1];

  // Search from ptr_q+1 upward with wrap; iterating downward lets the
  // nearest candidate overwrite farther ones.
  always_comb begin
    logic [IdWidth-1:0] cand;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int i = NumReq; i >= 1; i--) begin
      cand = IdWidth'((int'(ptr_q) + i) % NumReq);
      if (req_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A stale ack still visible after the previous transfer blocks grants.
        if (!ack_s && grant_vld) begin
          accept  = 1'b1;
          state_d = REQ_HI;
        end
      end
      REQ_HI:  if (ack_s)  state_d = REQ_LO;
      REQ_LO:  if (!ack_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gated by rst_i so ready reads zero the moment reset is asserted.
  always_comb begin
    req_ready_o = '0;
    if (accept && !rst_i) req_ready_o[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      async_req_o  <= 1'b0;
      async_data_o <= '0;
      async_id_o   <= '0;
      ptr_q        <= IdWidth'(NumReq - 1);
    end else if (accept) begin
      async_req_o  <= 1'b1;
      async_data_o <= req_data_i[grant_idx*DataWidth +: DataWidth];
      async_id_o   <= grant_idx;
      ptr_q        <= grant_idx;
    end else if (state_q == REQ_HI && ack_s) begin
      async_req_o  <= 1'b0;
    end
  end

  assign busy_o = (state_q != IDLE);

`ifdef SYNC_HANDSHAKE_ARB_TIMEOUT_EN
  localparam int CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  logic [CntWidth-1:0] cnt_q;
  logic                timeout_q;

  // cnt_q counts completed busy cycles in the current state; the flag is set
  // on the edge that ends the TimeoutCycles-th such cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (busy_o) begin
      if (cnt_q == CntWidth'(TimeoutCycles - 1)) timeout_q <= 1'b1;
      else                                       cnt_q     <= cnt_q + 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_sync_handshake_arb.sv
// Directed bench for sync_handshake_arb (NumReq=4, DataWidth=32, SyncStages=2,
// TimeoutCycles=16). Inputs change just after the falling clock edge; outputs
// are checked 1 time unit later, away from the rising edge.
module tb_sync_handshake_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   valid;
  logic [3:0]   ready;
  logic [127:0] data;
  logic         async_req;
  logic [31:0]  async_data;
  logic [1:0]   async_id;
  logic         ack;
  logic         busy;
  logic         timeout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_handshake_arb #(
    .NumReq(4), .DataWidth(32), .SyncStages(2), .TimeoutCycles(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(valid),
    .req_ready_o(ready),
    .req_data_i(data),
    .async_req_o(async_req),
    .async_data_o(async_data),
    .async_id_o(async_id),
    .async_ack_i(ack),
    .busy_o(busy),
    .timeout_o(timeout)
  );

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Raise ack, wait for req to fall, drop ack, wait for IDLE (both bounded).
  task automatic finish_handshake(input string tag);
    int n;
    ack = 1'b1;
    n = 0;
    do begin tick(); n++; end while (async_req === 1'b1 && n < 20);
    check_vec({tag, "_req_fall"}, 64'(async_req), 64'd0);
    ack = 1'b0;
    n = 0;
    do begin tick(); n++; end while (busy === 1'b1 && n < 20);
    check_vec({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int rr_order[5] = '{0, 1, 2, 3, 0};
    int rdy_cnt[4]  = '{0, 0, 0, 0};
    logic [3:0] obs_rdy;

    rst = 1'b1; valid = '0; data = '0; ack = 1'b0;
    repeat (3) tick();
    check_vec("rst_req",     64'(async_req),  64'd0);
    check_vec("rst_busy",    64'(busy),       64'd0);
    check_vec("rst_ready",   64'(ready),      64'd0);
    check_vec("rst_data",    64'(async_data), 64'd0);
    check_vec("rst_id",      64'(async_id),   64'd0);
    check_vec("rst_timeout", 64'(timeout),    64'd0);
    rst = 1'b0;
    tick();

    // Round robin with every requester asserting.
    for (int k = 0; k < 4; k++) data[k*32 +: 32] = 32'hA0A0_0000 + 32'(k);
    valid = 4'hF;
    #1;
    for (int t = 0; t < 5; t++) begin
      obs_rdy = ready;
      check_vec($sformatf("rr%0d_ready", t), 64'(obs_rdy), 64'd1 << rr_order[t]);
      for (int k = 0; k < 4; k++) if (obs_rdy[k]) rdy_cnt[k]++;
      tick();
      if (t == 4) valid = '0;
      check_vec($sformatf("rr%0d_req", t),  64'(async_req),  64'd1);
      check_vec($sformatf("rr%0d_id", t),   64'(async_id),   64'(rr_order[t]));
      check_vec($sformatf("rr%0d_data", t), 64'(async_data), 64'(32'hA0A0_0000 + 32'(rr_order[t])));
      check_vec($sformatf("rr%0d_busy_ready", t), 64'(ready), 64'd0);
      if (t == 3)
        for (int k = 0; k < 4; k++)
          check_vec($sformatf("rr_pulses%0d", k), 64'(rdy_cnt[k]), 64'd1);
      finish_handshake($sformatf("rr%0d", t));
    end

    // Stale ack while idle blocks the grant until the synchronizer clears.
    ack = 1'b1;
    repeat (3) tick();
    valid = 4'b0001;
    data[31:0] = 32'h5A5A_0001;
    #1;
    check_vec("stale_ready0", 64'(ready), 64'd0);
    tick();
    check_vec("stale_ready1", 64'(ready), 64'd0);
    check_vec("stale_req",    64'(async_req), 64'd0);
    check_vec("stale_busy",   64'(busy), 64'd0);
    ack = 1'b0;
    #1;
    check_vec("stale_drop_f0", 64'(ready), 64'd0);
    tick();
    check_vec("stale_drop_f1", 64'(ready), 64'd0);
    // ack_s clears after SyncStages edges; IDLE grants in that same cycle.
    tick();
    check_vec("stale_drop_f2", 64'(ready), 64'd1);
    tick();
    valid = '0;
    check_vec("stale_acc_req",  64'(async_req),  64'd1);
    check_vec("stale_acc_data", 64'(async_data), 64'h5A5A_0001);
    check_vec("stale_acc_id",   64'(async_id),   64'd0);
    finish_handshake("stale");

    // Single transfer with exact latencies: cycle 0 is the accept.
    valid = 4'b0100;
    data[64 +: 32] = 32'hDEAD_BEEF;
    #1;
    check_vec("st_ready_c0", 64'(ready), 64'b0100);
    tick();                                   // cycle 1
    valid = '0;
    check_vec("st_req_c1",  64'(async_req),  64'd1);
    check_vec("st_data_c1", 64'(async_data), 64'hDEAD_BEEF);
    check_vec("st_id_c1",   64'(async_id),   64'd2);
    tick();                                   // cycle 2
    tick();                                   // cycle 3
    ack = 1'b1;
    tick();                                   // cycle 4
    tick();                                   // cycle 5
    check_vec("st_req_c5",  64'(async_req), 64'd1);
    tick();                                   // cycle 6
    check_vec("st_req_c6",  64'(async_req), 64'd0);
    check_vec("st_busy_c6", 64'(busy),      64'd1);
    tick();                                   // cycle 7
    tick();                                   // cycle 8
    ack = 1'b0;
    valid = 4'b0001;
    data[31:0] = 32'h1111_1111;
    #1;
    check_vec("st_ready_c8", 64'(ready), 64'd0);
    tick();                                   // cycle 9
    tick();                                   // cycle 10
    check_vec("st_ready_c10", 64'(ready),      64'd0);
    check_vec("st_hold_c10",  64'(async_data), 64'hDEAD_BEEF);
    tick();                                   // cycle 11
    check_vec("st_ready_c11", 64'(ready), 64'b0001);
    tick();                                   // cycle 12
    valid = '0;
    check_vec("st2_req",  64'(async_req),  64'd1);
    check_vec("st2_data", 64'(async_data), 64'h1111_1111);
    check_vec("st2_id",   64'(async_id),   64'd0);
    finish_handshake("st2");

    // Reset in REQ_HI, then priority restarts at requester 0.
    valid = 4'b0010;
    data[32 +: 32] = 32'h0BAD_F00D;
    #1;
    check_vec("mr_ready", 64'(ready), 64'b0010);
    tick();
    valid = '0;
    check_vec("mr_req_hi", 64'(async_req), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_vec("mr_req_async",  64'(async_req),  64'd0);
    check_vec("mr_busy_async", 64'(busy),       64'd0);
    check_vec("mr_data_lost",  64'(async_data), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    valid = 4'b0110;
    data[64 +: 32] = 32'h2222_2222;
    #1;
    check_vec("mr_prio_ready", 64'(ready), 64'b0010);
    tick();
    valid = '0;
    check_vec("mr_prio_id",   64'(async_id),   64'd1);
    check_vec("mr_prio_data", 64'(async_data), 64'h0BAD_F00D);
    finish_handshake("mr");

`ifdef SYNC_HANDSHAKE_ARB_TIMEOUT_EN
    // Accept at cycle 0, REQ_HI from cycle 1; flag after 16 cycles there.
    valid = 4'b1000;
    data[96 +: 32] = 32'h7777_0003;
    #1;
    check_vec("to_ready", 64'(ready), 64'b1000);
    tick();
    valid = '0;
    repeat (15) tick();                       // cycle 16
    check_vec("to_c16", 64'(timeout), 64'd0);
    tick();                                   // cycle 17
    check_vec("to_c17", 64'(timeout), 64'd1);
    repeat (5) tick();
    check_vec("to_sticky", 64'(timeout),   64'd1);
    check_vec("to_req",    64'(async_req), 64'd1);
    finish_handshake("to");
    check_vec("to_after", 64'(timeout), 64'd1);
`else
    check_vec("timeout_off", 64'(timeout), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
